// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op encodings, FSM states and iteration count for ex_muldiv
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } muldiv_state_e;

    localparam int MULDIV_ITERS = 32;

endpackage

// File: rtl/muldiv_divstep.sv
// muldiv_divstep: one combinational restoring-division step
//   rem_i  partial remainder, bit_i next dividend bit, div_i divisor
//   rem_o  next partial remainder, q_o quotient bit
module muldiv_divstep (
    input  logic [31:0] rem_i,
    input  logic        bit_i,
    input  logic [31:0] div_i,
    output logic [31:0] rem_o,
    output logic        q_o
);

    logic [32:0] shifted;
    logic [32:0] diff;

    assign shifted = {rem_i, bit_i};
    assign diff    = shifted - {1'b0, div_i};
    // No borrow means shifted >= divisor; the remainder then always fits 32 bits
    assign q_o     = ~diff[32];
    assign rem_o   = q_o ? diff[31:0] : shifted[31:0];

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit for the execute stage
//   clk, rst      clock, asynchronous active-high reset
//   start         M-op present in EX; funct3 selects the op
//   op_a, op_b    rs1 / rs2 operands
//   flush         squash the in-flight op
//   stall         freeze PC, IF/ID, ID/EX while busy
//   done, result  one-cycle result pulse; result held until the next done
// Build option MULDIV_FAST_MUL_EN: single-cycle combinational multiply.
module ex_muldiv
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result
);

    muldiv_state_e state_q, state_d;
    muldiv_op_e    op_q, op_d;
    logic [4:0]    cnt_q, cnt_d;
    logic [31:0]   a_q, a_d;
    logic [31:0]   b_q, b_d;
    logic [63:0]   acc_q, acc_d;
    logic          neg_q, neg_d;
    logic [31:0]   result_q, result_d;
    logic          done_q, done_d;

    logic        signed_a, signed_b, neg_a, neg_b;
    logic [31:0] abs_a, abs_b;
    logic        div_zero, div_ovf, last;
    logic [32:0] mul_sum;
    logic [31:0] div_rem;
    logic        div_bit;
    logic [63:0] prod;
    logic [31:0] div_val, fin_res;

    assign signed_a = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
    assign signed_b = funct3[2] ? ~funct3[0] : ~funct3[1];
    assign neg_a    = signed_a & op_a[31];
    assign neg_b    = signed_b & op_b[31];
    assign abs_a    = neg_a ? -op_a : op_a;
    assign abs_b    = neg_b ? -op_b : op_b;
    assign div_zero = op_b == 32'h0;
    assign div_ovf  = signed_a && op_a == 32'h8000_0000 && op_b == 32'hFFFF_FFFF;
    assign last     = cnt_q == 5'(MULDIV_ITERS - 1);

`ifdef MULDIV_FAST_MUL_EN
    logic signed [32:0] ext_a, ext_b;
    logic signed [63:0] prod_fast;
    assign ext_a     = {neg_a, op_a};
    assign ext_b     = {neg_b, op_b};
    assign prod_fast = 64'(ext_a) * 64'(ext_b);
`endif

    // Shift-add: acc = {partial product, remaining multiplier bits}
    assign mul_sum = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_q} : 33'd0);

    // Restoring divide: acc = {partial remainder, dividend bits / quotient bits}
    muldiv_divstep u_divstep (
        .rem_i (acc_q[63:32]),
        .bit_i (acc_q[31]),
        .div_i (b_q),
        .rem_o (div_rem),
        .q_o   (div_bit)
    );

    assign prod    = neg_q ? -acc_q : acc_q;
    assign div_val = op_q[1] ? acc_q[63:32] : acc_q[31:0];
    assign fin_res = op_q[2] ? (neg_q ? -div_val : div_val)
                   : (op_q == OP_MUL ? prod[31:0] : prod[63:32]);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        result_d = result_q;
        done_d   = 1'b0;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start) begin
                    op_d  = muldiv_op_e'(funct3);
                    cnt_d = 5'd0;
                    a_d   = abs_a;
                    b_d   = abs_b;
                    // Remainder follows the dividend; everything else uses the product sign
                    neg_d = (funct3[2] & funct3[1]) ? neg_a : neg_a ^ neg_b;
                    if (funct3[2]) begin
                        if (div_zero) begin
                            acc_d   = {op_a, 32'hFFFF_FFFF};
                            neg_d   = 1'b0;
                            state_d = ST_DONE;
                        end else if (div_ovf) begin
                            acc_d   = {32'h0, 32'h8000_0000};
                            neg_d   = 1'b0;
                            state_d = ST_DONE;
                        end else begin
                            acc_d   = {32'h0, abs_a};
                            state_d = ST_DIV;
                        end
                    end else begin
`ifdef MULDIV_FAST_MUL_EN
                        acc_d   = prod_fast;
                        neg_d   = 1'b0;
                        state_d = ST_DONE;
`else
                        acc_d   = {32'h0, abs_b};
                        state_d = ST_MUL;
`endif
                    end
                end
                ST_MUL: begin
                    acc_d   = {mul_sum, acc_q[31:1]};
                    cnt_d   = cnt_q + 5'd1;
                    state_d = last ? ST_DONE : ST_MUL;
                end
                ST_DIV: begin
                    acc_d   = {div_rem, acc_q[30:0], div_bit};
                    cnt_d   = cnt_q + 5'd1;
                    state_d = last ? ST_DONE : ST_DIV;
                end
                ST_DONE: begin
                    result_d = fin_res;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_MUL;
            cnt_q    <= 5'd0;
            a_q      <= 32'h0;
            b_q      <= 32'h0;
            acc_q    <= 64'h0;
            neg_q    <= 1'b0;
            result_q <= 32'h0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign stall  = (start & state_q == ST_IDLE & ~flush) | state_q == ST_MUL | state_q == ST_DIV;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: scoreboard bench for ex_muldiv with directed RV32M vectors
module tb_ex_muldiv;

`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST_MUL = 1'b1;
`else
    localparam bit FAST_MUL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] result;

    typedef struct {
        logic [31:0] r;
        int          c;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;

    ex_muldiv #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .flush  (flush),
        .stall  (stall),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done) begin
            if (sbq.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("result", result, e.r);
                check("done_cycle", 32'(cyc), 32'(e.c));
            end
        end
    end

    // Present an op and hold it (start high) until the DONE cycle, as a stalled ID/EX would.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] r, input bit fast_div);
        bit fast;
        int n;
        exp_t e;
        fast   = fast_div || (!f[2] && FAST_MUL);
        funct3 = f;
        op_a   = a;
        op_b   = b;
        start  = 1'b1;
        e.r    = r;
        e.c    = cyc + (fast ? 2 : 34);
        sbq.push_back(e);
        #1;
        n = 0;
        while (stall && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("stall_cycles", 32'(n), fast ? 32'd1 : 32'd33);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] saved;
        rst    = 1'b1;
        start  = 1'b0;
        flush  = 1'b0;
        funct3 = 3'b000;
        op_a   = 32'h0;
        op_b   = 32'h0;
        repeat (2) @(negedge clk);
        check("reset_result", result, 32'h0);
        check("reset_done", 32'(done), 32'h0);
        check("reset_stall", 32'(stall), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        run_op(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
        run_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
        run_op(3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0);
        run_op(3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 1'b0);
        start = 1'b0;
        @(negedge clk);
        run_op(3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0);
        run_op(3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0);
        run_op(3'b101, 32'd100, 32'd7, 32'd14, 1'b0);
        run_op(3'b111, 32'd100, 32'd7, 32'd2, 1'b0);
        run_op(3'b100, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0);
        run_op(3'b110, 32'd7, 32'hFFFF_FFFE, 32'd1, 1'b0);
        run_op(3'b101, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 1'b0);
        start = 1'b0;
        @(negedge clk);
        run_op(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
        run_op(3'b110, 32'd5, 32'd0, 32'd5, 1'b1);
        run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
        run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
        run_op(3'b111, 32'd100, 32'd7, 32'd2, 1'b0);
        start = 1'b0;
        @(negedge clk);

        // Flush a divide at counter 10: back to IDLE, no done, result untouched
        saved  = result;
        funct3 = 3'b101;
        op_a   = 32'd1000;
        op_b   = 32'd3;
        start  = 1'b1;
        repeat (11) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        #1;
        check("flush_idle_stall", 32'(stall), 32'h0);
        check("flush_result", result, saved);
        flush = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("flush_result_hold", result, saved);

        // Reset in the middle of a multiply clears everything without a clock edge
        funct3 = 3'b000;
        op_a   = 32'd9;
        op_b   = 32'd9;
        start  = 1'b1;
        repeat (5) @(negedge clk);
        #2;
        rst   = 1'b1;
        start = 1'b0;
        #1;
        check("rst_result", result, 32'h0);
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Back-to-back with start held across both ops
        run_op(3'b000, 32'd6, 32'd7, 32'd42, 1'b0);
        run_op(3'b100, 32'd42, 32'hFFFF_FFFA, 32'hFFFF_FFF9, 1'b0);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pending_results", 32'(sbq.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
